// File: rtl/ariane_soc_pkg.sv
// SoC memory-map constants and the reset rule table used by the address-map decoder.
// Rule order is routing priority: DRAM first, Debug last.
package ariane_soc;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] len;
    } addr_rule_t;

    localparam int unsigned NrSocRules = 10;

    localparam logic [63:0] DRAMBase     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DRAMLength   = 64'h0000_0000_1000_0000;
    localparam logic [63:0] GPIOBase     = 64'h0000_0000_4000_0000;
    localparam logic [63:0] GPIOLength   = 64'h0000_0000_0000_1000;
    localparam logic [63:0] EthBase      = 64'h0000_0000_3000_0000;
    localparam logic [63:0] EthLength    = 64'h0000_0000_0001_0000;
    localparam logic [63:0] SPIBase      = 64'h0000_0000_2000_0000;
    localparam logic [63:0] SPILength    = 64'h0000_0000_0080_0000;
    localparam logic [63:0] TimerBase    = 64'h0000_0000_1800_0000;
    localparam logic [63:0] TimerLength  = 64'h0000_0000_0000_1000;
    localparam logic [63:0] UARTBase     = 64'h0000_0000_1000_0000;
    localparam logic [63:0] UARTLength   = 64'h0000_0000_0000_1000;
    localparam logic [63:0] PLICBase     = 64'h0000_0000_0C00_0000;
    localparam logic [63:0] PLICLength   = 64'h0000_0000_03FF_FFFF;
    localparam logic [63:0] CLINTBase    = 64'h0000_0000_0200_0000;
    localparam logic [63:0] CLINTLength  = 64'h0000_0000_000C_0000;
    localparam logic [63:0] ROMBase      = 64'h0000_0000_0001_0000;
    localparam logic [63:0] ROMLength    = 64'h0000_0000_0001_0000;
    localparam logic [63:0] DebugBase    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] DebugLength  = 64'h0000_0000_0000_1000;

    typedef addr_rule_t [NrSocRules-1:0] soc_rules_t;

    function automatic soc_rules_t soc_rst_rules();
        soc_rules_t r;
        r[0] = '{base: DRAMBase,  len: DRAMLength};
        r[1] = '{base: GPIOBase,  len: GPIOLength};
        r[2] = '{base: EthBase,   len: EthLength};
        r[3] = '{base: SPIBase,   len: SPILength};
        r[4] = '{base: TimerBase, len: TimerLength};
        r[5] = '{base: UARTBase,  len: UARTLength};
        r[6] = '{base: PLICBase,  len: PLICLength};
        r[7] = '{base: CLINTBase, len: CLINTLength};
        r[8] = '{base: ROMBase,   len: ROMLength};
        r[9] = '{base: DebugBase, len: DebugLength};
        return r;
    endfunction

    localparam soc_rules_t SocRstRules = soc_rst_rules();

endpackage

// File: rtl/addr_rule_match.sv
// One address-map rule checked against one address; purely combinational.
// The offset is taken modulo 2^AddrWidth so a region touching the top of memory still matches.
module addr_rule_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [AddrWidth-1:0] base,
    input  logic [AddrWidth-1:0] len,
    output logic                 match
);

    logic [AddrWidth-1:0] offset;

    assign offset = addr - base;
    assign match  = (len != '0) && (addr >= base) && (offset < len);

endmodule

// File: rtl/soc_addr_map_decoder.sv
// Programmable, one-stage pipelined address-map decoder with a lockable rule table.
// Define SOC_ADDR_DEC_ERRLOG_EN to add the sticky miss log (err_valid_o/err_addr_o/err_cnt_o/err_clr_i).
module soc_addr_map_decoder
    import ariane_soc::*;
#(
    parameter int unsigned NrRules   = 10,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1,
    parameter addr_rule_t [NrRules-1:0] RstRules = SocRstRules
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [4:0]           cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_err_o,
    output logic                 locked_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [IdxWidth-1:0]  resp_idx_o,
    output logic                 resp_miss_o,
`ifdef SOC_ADDR_DEC_ERRLOG_EN
    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [7:0]           err_cnt_o,
    input  logic                 err_clr_i,
`endif
    output logic [AddrWidth-1:0] resp_addr_o
);

    localparam logic [5:0] NrRulesW = 6'(NrRules);

    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic                 locked_q;
    logic                 cfg_err_q;
    logic                 cfg_ok;

    logic [NrRules-1:0]   hit;
    logic [IdxWidth-1:0]  dec_idx;
    logic                 dec_miss;

    logic                 resp_valid_q;
    logic                 resp_miss_q;
    logic [IdxWidth-1:0]  resp_idx_q;
    logic [AddrWidth-1:0] resp_addr_q;
    logic                 req_fire;

    // Rule table
    assign cfg_ok = cfg_we_i && !locked_q && ({1'b0, cfg_idx_i} < NrRulesW);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRules; i++) begin
                base_q[i] <= RstRules[i].base[AddrWidth-1:0];
                len_q[i]  <= RstRules[i].len[AddrWidth-1:0];
            end
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NrRules; i++) begin
                if (cfg_ok && (cfg_idx_i == 5'(i))) begin
                    base_q[i] <= cfg_base_i;
                    len_q[i]  <= cfg_len_i;
                end
            end
            if (cfg_ok && cfg_lock_i) begin
                locked_q <= 1'b1;
            end
            cfg_err_q <= cfg_we_i && !cfg_ok;
        end
    end

    assign locked_o  = locked_q;
    assign cfg_err_o = cfg_err_q;

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        addr_rule_match #(
            .AddrWidth (AddrWidth)
        ) u_match (
            .addr  (req_addr_i),
            .base  (base_q[g]),
            .len   (len_q[g]),
            .match (hit[g])
        );
    end

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        dec_idx  = '0;
        dec_miss = 1'b1;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_idx  = IdxWidth'(i);
                dec_miss = 1'b0;
            end
        end
    end

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // the request side may only fire when the output register is empty or being drained.
    assign req_ready_o = !resp_valid_q || resp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_miss_q  <= 1'b0;
            resp_idx_q   <= '0;
            resp_addr_q  <= '0;
        end else if (req_fire) begin
            resp_valid_q <= 1'b1;
            resp_miss_q  <= dec_miss;
            resp_idx_q   <= dec_idx;
            resp_addr_q  <= req_addr_i;
        end else if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_miss_o  = resp_miss_q;
    assign resp_idx_o   = resp_idx_q;
    assign resp_addr_o  = resp_addr_q;

`ifdef SOC_ADDR_DEC_ERRLOG_EN
    logic                 miss_handoff;
    logic                 err_valid_q;
    logic [AddrWidth-1:0] err_addr_q;
    logic [7:0]           err_cnt_q;

    assign miss_handoff = resp_valid_q && resp_ready_i && resp_miss_q;

    // A clear coinciding with a miss hand-off restarts the log from that miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else if (err_clr_i) begin
            err_valid_q <= miss_handoff;
            err_addr_q  <= miss_handoff ? resp_addr_q : '0;
            err_cnt_q   <= miss_handoff ? 8'd1 : 8'd0;
        end else if (miss_handoff) begin
            if (!err_valid_q) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= resp_addr_q;
            end
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_soc_addr_map_decoder.sv
// Self-checking bench for soc_addr_map_decoder: directed vectors, handshake corners and
// randomized traffic checked against an address-map model kept in the bench.
module tb_soc_addr_map_decoder;

    localparam int NR = 10;
    localparam int IW = 4;
    localparam int W  = 1 + IW + 64;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_we_i;
    logic [4:0]  cfg_idx_i;
    logic [63:0] cfg_base_i;
    logic [63:0] cfg_len_i;
    logic        cfg_lock_i;
    logic        cfg_err_o;
    logic        locked_o;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [IW-1:0] resp_idx_o;
    logic        resp_miss_o;
    logic [63:0] resp_addr_o;
`ifdef SOC_ADDR_DEC_ERRLOG_EN
    logic        err_valid_o;
    logic [63:0] err_addr_o;
    logic [7:0]  err_cnt_o;
    logic        err_clr_i;
`endif

    soc_addr_map_decoder dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_base_i   (cfg_base_i),
        .cfg_len_i    (cfg_len_i),
        .cfg_lock_i   (cfg_lock_i),
        .cfg_err_o    (cfg_err_o),
        .locked_o     (locked_o),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_idx_o   (resp_idx_o),
        .resp_miss_o  (resp_miss_o),
`ifdef SOC_ADDR_DEC_ERRLOG_EN
        .err_valid_o  (err_valid_o),
        .err_addr_o   (err_addr_o),
        .err_cnt_o    (err_cnt_o),
        .err_clr_i    (err_clr_i),
`endif
        .resp_addr_o  (resp_addr_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test completed");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // reference model: memory map as arrays, decoded by first-match scan
    logic [63:0] rst_base [NR] = '{64'h8000_0000, 64'h4000_0000, 64'h3000_0000, 64'h2000_0000,
                                   64'h1800_0000, 64'h1000_0000, 64'h0C00_0000, 64'h0200_0000,
                                   64'h0001_0000, 64'h0};
    logic [63:0] rst_len  [NR] = '{64'h1000_0000, 64'h1000, 64'h1_0000, 64'h80_0000,
                                   64'h1000, 64'h1000, 64'h3FF_FFFF, 64'hC_0000,
                                   64'h1_0000, 64'h1000};
    logic [63:0] base_m [NR];
    logic [63:0] len_m  [NR];
    logic        lock_m;
    logic        err_exp;
    logic [W-1:0] exp_q[$];
`ifdef SOC_ADDR_DEC_ERRLOG_EN
    logic        ev_m;
    logic [63:0] ea_m;
    int          ec_m;
`endif

    function automatic logic [W-1:0] model_decode(input logic [63:0] a);
        for (int i = 0; i < NR; i++) begin
            if (len_m[i] != 0 && a >= base_m[i] && (a - base_m[i]) < len_m[i])
                return {1'b0, IW'(i), a};
        end
        return {1'b1, {IW{1'b0}}, a};
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NR; i++) begin
            base_m[i] = rst_base[i];
            len_m[i]  = rst_len[i];
        end
        lock_m  = 1'b0;
        err_exp = 1'b0;
        exp_q.delete();
`ifdef SOC_ADDR_DEC_ERRLOG_EN
        ev_m = 1'b0;
        ea_m = '0;
        ec_m = 0;
`endif
    endtask

    // scoreboard: checks outputs every cycle, then advances the model by this cycle's inputs
    always @(negedge clk_i) begin
        if (rst_ni) begin
            logic handoff;
            logic accept;
            chk("resp_valid", resp_valid_o, exp_q.size() != 0);
            chk("req_ready", req_ready_o, (exp_q.size() == 0) || resp_ready_i);
            if (exp_q.size() != 0)
                chk("resp_data", {resp_miss_o, resp_idx_o, resp_addr_o}, exp_q[0]);
            chk("cfg_err", cfg_err_o, err_exp);
            chk("locked", locked_o, lock_m);
`ifdef SOC_ADDR_DEC_ERRLOG_EN
            chk("err_valid", err_valid_o, ev_m);
            chk("err_addr", err_addr_o, ea_m);
            chk("err_cnt", err_cnt_o, 8'(ec_m));
`endif
            handoff = (exp_q.size() != 0) && resp_ready_i;
            accept  = req_valid_i && ((exp_q.size() == 0) || resp_ready_i);
`ifdef SOC_ADDR_DEC_ERRLOG_EN
            if (err_clr_i) begin
                ev_m = handoff && exp_q[0][W-1];
                ea_m = ev_m ? exp_q[0][63:0] : '0;
                ec_m = ev_m ? 1 : 0;
            end else if (handoff && exp_q[0][W-1]) begin
                if (!ev_m) begin
                    ev_m = 1'b1;
                    ea_m = exp_q[0][63:0];
                end
                if (ec_m < 255) ec_m++;
            end
`endif
            if (handoff) void'(exp_q.pop_front());
            if (accept) exp_q.push_back(model_decode(req_addr_i));
            err_exp = cfg_we_i && (lock_m || cfg_idx_i >= 5'(NR));
            if (cfg_we_i && !err_exp) begin
                base_m[cfg_idx_i] = cfg_base_i;
                len_m[cfg_idx_i]  = cfg_len_i;
                if (cfg_lock_i) lock_m = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic req_check(input string name, input logic [63:0] a, input logic m, input logic [IW-1:0] idx);
        req_valid_i  = 1'b1;
        req_addr_i   = a;
        resp_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk({name, "_valid"}, resp_valid_o, 1'b1);
        chk({name, "_miss"}, resp_miss_o, m);
        chk({name, "_idx"}, resp_idx_o, idx);
        step();
    endtask

    task automatic cfg_write(input logic [4:0] idx, input logic [63:0] b, input logic [63:0] l, input logic lk);
        cfg_we_i   = 1'b1;
        cfg_idx_i  = idx;
        cfg_base_i = b;
        cfg_len_i  = l;
        cfg_lock_i = lk;
        step();
        cfg_we_i   = 1'b0;
        cfg_lock_i = 1'b0;
    endtask

    task automatic drain();
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        cfg_we_i     = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        chk("drain_empty", exp_q.size() == 0, 1'b1);
        step();
    endtask

    function automatic logic [63:0] pick_addr();
        int k;
        k = $urandom_range(0, NR - 1);
        case ($urandom_range(0, 3))
            0: return (len_m[k] != 0) ? base_m[k] + ({$urandom, $urandom} % len_m[k]) : base_m[k];
            1: return base_m[k] + len_m[k];
            2: return base_m[k] - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    typedef struct {
        logic [63:0]   addr;
        logic          miss;
        logic [IW-1:0] idx;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{64'h8000_0000, 1'b0, 4'd0};
        vecs[1] = '{64'h8FFF_FFFF, 1'b0, 4'd0};
        vecs[2] = '{64'h9000_0000, 1'b1, 4'd0};
        vecs[3] = '{64'h1000_0010, 1'b0, 4'd5};
        vecs[4] = '{64'h1000_1000, 1'b1, 4'd0};
        vecs[5] = '{64'h7000_0000, 1'b1, 4'd0};
        vecs[6] = '{64'h0,         1'b0, 4'd9};
        vecs[7] = '{64'h0C00_0000, 1'b0, 4'd6};
        vecs[8] = '{64'h4000_0FFF, 1'b0, 4'd1};
        vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0};

        rst_ni = 1'b0;
        cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_base_i = '0; cfg_len_i = '0; cfg_lock_i = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b0;
`ifdef SOC_ADDR_DEC_ERRLOG_EN
        err_clr_i = 1'b0;
`endif
        reset_model();
        #1;
        chk("rst_resp_valid", resp_valid_o, 1'b0);
        chk("rst_resp_idx", resp_idx_o, 4'd0);
        chk("rst_resp_miss", resp_miss_o, 1'b0);
        chk("rst_resp_addr", resp_addr_o, 64'd0);
        chk("rst_locked", locked_o, 1'b0);
        chk("rst_cfg_err", cfg_err_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step();

        // reset memory map decode
        for (int k = 0; k < 10; k++) req_check("vec", vecs[k].addr, vecs[k].miss, vecs[k].idx);

        // backpressure: second request waits while the first result is held
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b1;
        req_addr_i   = 64'h8000_0040;
        step();
        req_addr_i = 64'h1000_0020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_ready_low", req_ready_o, 1'b0);
            chk("bp_hold_addr", resp_addr_o, 64'h8000_0040);
            step();
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_first_addr", resp_addr_o, 64'h8000_0040);
        step();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_second_valid", resp_valid_o, 1'b1);
        chk("bp_second_addr", resp_addr_o, 64'h1000_0020);
        chk("bp_second_idx", resp_idx_o, 4'd5);
        step();
        drain();

        // rewrite rule 2 in the same cycle as a request that would hit it
        cfg_we_i = 1'b1; cfg_idx_i = 5'd2; cfg_base_i = 64'h9000_0000; cfg_len_i = 64'h1000;
        req_valid_i = 1'b1; req_addr_i = 64'h9000_0000; resp_ready_i = 1'b1;
        step();
        cfg_we_i = 1'b0;
        @(negedge clk_i);
        chk("rw_old_miss", resp_miss_o, 1'b1);
        step();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rw_new_miss", resp_miss_o, 1'b0);
        chk("rw_new_idx", resp_idx_o, 4'd2);
        step();

        // out-of-range index
        cfg_write(5'd31, 64'h0, 64'h0, 1'b0);
        @(negedge clk_i);
        chk("oor_err_pulse", cfg_err_o, 1'b1);
        step();
        @(negedge clk_i);
        chk("oor_err_clear", cfg_err_o, 1'b0);
        step();

        // overlap, top of address space, disabled rule
        cfg_write(5'd1, 64'h8000_0000, 64'h1000, 1'b0);
        cfg_write(5'd3, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 1'b0);
        cfg_write(5'd5, 64'h1000_0000, 64'h0, 1'b0);
        req_check("ovl", 64'h8000_0010, 1'b0, 4'd0);
        req_check("top", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd3);
        req_check("top_below", 64'hFFFF_FFFF_FFFF_EFFF, 1'b1, 4'd0);
        req_check("disabled", 64'h1000_0010, 1'b1, 4'd0);

        // randomized traffic and rewrites
        repeat (400) begin
            req_valid_i  = ($urandom_range(0, 3) != 0);
            resp_ready_i = ($urandom_range(0, 3) != 0);
            req_addr_i   = pick_addr();
            cfg_we_i     = ($urandom_range(0, 15) == 0);
            cfg_idx_i    = 5'($urandom_range(0, 12));
            cfg_base_i   = pick_addr();
            cfg_len_i    = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 65536));
            step();
        end
        drain();

        // asynchronous reset with a result pending
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b1;
        req_addr_i   = 64'h8000_0000;
        step();
        req_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_valid", resp_valid_o, 1'b0);
        reset_model();
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        req_check("post_rst", 64'h9000_0000, 1'b1, 4'd0);

        // lock
        cfg_write(5'd4, 64'h5000_0000, 64'h100, 1'b1);
        @(negedge clk_i);
        chk("lock_set", locked_o, 1'b1);
        chk("lock_no_err", cfg_err_o, 1'b0);
        step();
        cfg_write(5'd0, 64'h0, 64'h0, 1'b0);
        @(negedge clk_i);
        chk("locked_err_pulse", cfg_err_o, 1'b1);
        step();
        @(negedge clk_i);
        chk("locked_err_clear", cfg_err_o, 1'b0);
        chk("lock_sticky", locked_o, 1'b1);
        step();
        req_check("locked_unchanged", 64'h8000_0000, 1'b0, 4'd0);
        req_check("lock_write_took", 64'h5000_0080, 1'b0, 4'd4);

`ifdef SOC_ADDR_DEC_ERRLOG_EN
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        resp_ready_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 64'h7000_0000 + 64'(k * 16);
            step();
        end
        drain();
        @(negedge clk_i);
        chk("elog_cnt_sat", err_cnt_o, 8'd255);
        chk("elog_first_addr", err_addr_o, 64'h7000_0000);
        chk("elog_valid", err_valid_o, 1'b1);
        step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        @(negedge clk_i);
        chk("elog_clr_cnt", err_cnt_o, 8'd0);
        chk("elog_clr_addr", err_addr_o, 64'd0);
        chk("elog_clr_valid", err_valid_o, 1'b0);
        step();
`endif

        drain();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
